// File: rtl/id_ex_ctrl_if.sv
// Decode-to-execute control bus: IF/ID inputs plus the registered ID/EX control outputs.
// master drives the decode side and observes EX controls; slave is the ID/EX stage.
interface id_ex_ctrl_if #(
    parameter int REG_AW = 5
);
    logic              id_valid;
    logic [31:0]       id_instr;
    logic              ext_stall;
    logic              flush;
    logic              hazard_stall;
    logic              ex_valid;
    logic [1:0]        ex_aluOp;
    logic [3:0]        ex_func;
    logic              ex_aluSrc;
    logic              ex_regDst;
    logic              ex_regWrite;
    logic              ex_memRead;
    logic              ex_memWrite;
    logic              ex_memToReg;
    logic              ex_branch;
    logic [REG_AW-1:0] ex_rs;
    logic [REG_AW-1:0] ex_rt;
    logic [REG_AW-1:0] ex_rd;
    logic [15:0]       ex_imm;
    logic              illegal_op;

    modport master (
        output id_valid, id_instr, ext_stall, flush,
        input  hazard_stall, ex_valid, ex_aluOp, ex_func, ex_aluSrc, ex_regDst,
               ex_regWrite, ex_memRead, ex_memWrite, ex_memToReg, ex_branch,
               ex_rs, ex_rt, ex_rd, ex_imm, illegal_op
    );

    modport slave (
        input  id_valid, id_instr, ext_stall, flush,
        output hazard_stall, ex_valid, ex_aluOp, ex_func, ex_aluSrc, ex_regDst,
               ex_regWrite, ex_memRead, ex_memWrite, ex_memToReg, ex_branch,
               ex_rs, ex_rt, ex_rd, ex_imm, illegal_op
    );
endinterface

// File: rtl/id_ex_ctrl_stage.sv
// ID/EX control stage: decodes IF/ID, detects load-use hazards, registers controls (1-cycle latency).
// ext_stall freezes the register; flush, hazards, invalid and illegal instructions load a bubble.
module id_ex_ctrl_stage #(
    parameter int REG_AW        = 5,
    parameter bit HAZ_IGNORE_R0 = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    id_ex_ctrl_if.slave  bus
);
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_J     = 6'b000010;

    typedef struct packed {
        logic alu_src;
        logic reg_dst;
        logic reg_write;
        logic mem_read;
        logic mem_write;
        logic mem_to_reg;
        logic branch;
    } ctrl_t;

    typedef struct packed {
        logic              valid;
        logic [1:0]        alu_op;
        logic [3:0]        func;
        ctrl_t             ctrl;
        logic [REG_AW-1:0] rs;
        logic [REG_AW-1:0] rt;
        logic [REG_AW-1:0] rd;
        logic [15:0]       imm;
    } idex_t;

    logic [5:0]        op;
    logic [REG_AW-1:0] id_rs;
    logic [REG_AW-1:0] id_rt;
    logic [REG_AW-1:0] id_rd;
    logic              legal;
    logic              uses_rt;
    logic              hazard;
    idex_t             dec;
    idex_t             q;
    logic              illegal_q;

    assign op    = bus.id_instr[31:26];
    assign id_rs = REG_AW'(bus.id_instr[25:21]);
    assign id_rt = REG_AW'(bus.id_instr[20:16]);
    assign id_rd = REG_AW'(bus.id_instr[15:11]);

    always_comb begin
        dec       = '0;
        legal     = 1'b1;
        dec.valid = 1'b1;
        dec.rs    = id_rs;
        dec.rt    = id_rt;
        dec.rd    = id_rd;
        dec.imm   = bus.id_instr[15:0];
        case (op)
            OP_RTYPE: begin
                dec.alu_op         = 2'b00;
                dec.func           = bus.id_instr[3:0];
                dec.ctrl.reg_dst   = 1'b1;
                dec.ctrl.reg_write = 1'b1;
            end
            OP_ADDI: begin
                dec.alu_op         = 2'b11;
                dec.ctrl.alu_src   = 1'b1;
                dec.ctrl.reg_write = 1'b1;
            end
            OP_LW: begin
                dec.alu_op          = 2'b11;
                dec.ctrl.alu_src    = 1'b1;
                dec.ctrl.mem_read   = 1'b1;
                dec.ctrl.mem_to_reg = 1'b1;
                dec.ctrl.reg_write  = 1'b1;
            end
            OP_SW: begin
                dec.alu_op         = 2'b11;
                dec.ctrl.alu_src   = 1'b1;
                dec.ctrl.mem_write = 1'b1;
            end
            OP_BEQ: begin
                dec.alu_op      = 2'b01;
                dec.ctrl.branch = 1'b1;
            end
            OP_ORI: begin
                dec.alu_op         = 2'b10;
                dec.ctrl.alu_src   = 1'b1;
                dec.ctrl.reg_write = 1'b1;
            end
            OP_J: begin
                dec.alu_op = 2'b11;
            end
            default: begin
                legal = 1'b0;
            end
        endcase
    end

    // Only R-type, sw and beq actually read rt as a source operand.
    assign uses_rt = (op == OP_RTYPE) || (op == OP_SW) || (op == OP_BEQ);

    assign hazard = bus.id_valid && q.valid && q.ctrl.mem_read && !bus.flush
                 && ((q.rt == id_rs) || ((q.rt == id_rt) && uses_rt))
                 && (!HAZ_IGNORE_R0 || (q.rt != '0));

    always_ff @(posedge clk) begin
        if (rst) begin
            q         <= '0;
            illegal_q <= 1'b0;
        end else if (!bus.ext_stall) begin
            if (bus.flush || hazard) begin
                q <= '0;
            end else if (!bus.id_valid || !legal) begin
                q <= '0;
                if (bus.id_valid) begin
                    illegal_q <= 1'b1;
                end
            end else begin
                q <= dec;
            end
        end
    end

    assign bus.hazard_stall = hazard;
    assign bus.ex_valid     = q.valid;
    assign bus.ex_aluOp     = q.alu_op;
    assign bus.ex_func      = q.func;
    assign bus.ex_aluSrc    = q.ctrl.alu_src;
    assign bus.ex_regDst    = q.ctrl.reg_dst;
    assign bus.ex_regWrite  = q.ctrl.reg_write;
    assign bus.ex_memRead   = q.ctrl.mem_read;
    assign bus.ex_memWrite  = q.ctrl.mem_write;
    assign bus.ex_memToReg  = q.ctrl.mem_to_reg;
    assign bus.ex_branch    = q.ctrl.branch;
    assign bus.ex_rs        = q.rs;
    assign bus.ex_rt        = q.rt;
    assign bus.ex_rd        = q.rd;
    assign bus.ex_imm       = q.imm;
    assign bus.illegal_op   = illegal_q;
endmodule

// File: tb/tb_id_ex_ctrl_stage.sv
// Directed bench for id_ex_ctrl_stage: expected ID/EX contents are queued as each
// instruction is driven and compared once the register has captured it.
module tb_id_ex_ctrl_stage;
    typedef struct packed {
        logic        valid;
        logic [1:0]  aluop;
        logic [3:0]  func;
        logic [6:0]  ctl;   // aluSrc regDst regWrite memRead memWrite memToReg branch
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [15:0] imm;
    } ex_t;

    logic clk;
    logic rst;
    int   errors;
    int   checks;
    ex_t  exp_q[$];

    id_ex_ctrl_if #(.REG_AW(5)) bus ();

    id_ex_ctrl_stage #(.REG_AW(5), .HAZ_IGNORE_R0(1'b1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    localparam logic [31:0] I_RT   = 32'h00A41025;
    localparam logic [31:0] I_LW3  = 32'h8C230010;
    localparam logic [31:0] I_LW0  = 32'h8C200010;
    localparam logic [31:0] I_ADD3 = 32'h00622020;
    localparam logic [31:0] I_ADD0 = 32'h00002020;
    localparam logic [31:0] I_ADDI = 32'h20230007;
    localparam logic [31:0] I_SW   = 32'hAC230004;
    localparam logic [31:0] I_BEQ  = 32'h10220003;
    localparam logic [31:0] I_ORI  = 32'h344500FF;
    localparam logic [31:0] I_J    = 32'h08000010;
    localparam logic [31:0] I_ILL  = 32'hFC000000;

    function automatic ex_t mk(input logic v, input logic [1:0] a, input logic [3:0] f,
                               input logic [6:0] c, input logic [4:0] s, input logic [4:0] t,
                               input logic [4:0] d, input logic [15:0] i);
        mk = {v, a, f, c, s, t, d, i};
    endfunction

    function automatic ex_t observe();
        observe = {bus.ex_valid, bus.ex_aluOp, bus.ex_func,
                   bus.ex_aluSrc, bus.ex_regDst, bus.ex_regWrite, bus.ex_memRead,
                   bus.ex_memWrite, bus.ex_memToReg, bus.ex_branch,
                   bus.ex_rs, bus.ex_rt, bus.ex_rd, bus.ex_imm};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Drive one cycle of inputs, check the combinational hazard, then the registered result.
    task automatic step(input string tag, input logic v, input logic [31:0] ins,
                        input logic st, input logic fl, input logic r,
                        input logic exp_haz, input ex_t e, input logic exp_ill);
        ex_t want;
        @(negedge clk);
        bus.id_valid  = v;
        bus.id_instr  = ins;
        bus.ext_stall = st;
        bus.flush     = fl;
        rst           = r;
        #1;
        chk({tag, ":haz"}, 64'(bus.hazard_stall), 64'(exp_haz));
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        want = exp_q.pop_front();
        chk({tag, ":ex"}, 64'(observe()), 64'(want));
        chk({tag, ":ill"}, 64'(bus.illegal_op), 64'(exp_ill));
    endtask

    initial begin
        ex_t b, e_rt, e_lw3, e_lw0, e_add3, e_add0, e_addi, e_sw, e_beq, e_ori, e_j;
        errors = 0;
        checks = 0;
        b      = '0;
        e_rt   = mk(1'b1, 2'b00, 4'h5, 7'b0110000, 5'd5, 5'd4, 5'd2, 16'h1025);
        e_lw3  = mk(1'b1, 2'b11, 4'h0, 7'b1011010, 5'd1, 5'd3, 5'd0, 16'h0010);
        e_lw0  = mk(1'b1, 2'b11, 4'h0, 7'b1011010, 5'd1, 5'd0, 5'd0, 16'h0010);
        e_add3 = mk(1'b1, 2'b00, 4'h0, 7'b0110000, 5'd3, 5'd2, 5'd4, 16'h2020);
        e_add0 = mk(1'b1, 2'b00, 4'h0, 7'b0110000, 5'd0, 5'd0, 5'd4, 16'h2020);
        e_addi = mk(1'b1, 2'b11, 4'h0, 7'b1010000, 5'd1, 5'd3, 5'd0, 16'h0007);
        e_sw   = mk(1'b1, 2'b11, 4'h0, 7'b1000100, 5'd1, 5'd3, 5'd0, 16'h0004);
        e_beq  = mk(1'b1, 2'b01, 4'h0, 7'b0000001, 5'd1, 5'd2, 5'd0, 16'h0003);
        e_ori  = mk(1'b1, 2'b10, 4'h0, 7'b1010000, 5'd2, 5'd5, 5'd0, 16'h00FF);
        e_j    = mk(1'b1, 2'b11, 4'h0, 7'b0000000, 5'd0, 5'd0, 5'd0, 16'h0010);

        rst           = 1'b1;
        bus.id_valid  = 1'b1;
        bus.id_instr  = I_RT;
        bus.ext_stall = 1'b0;
        bus.flush     = 1'b0;
        @(posedge clk);

        // Reset with a valid instruction presented
        step("rst",        1, I_RT,   0, 0, 1, 0, b,      0);
        step("rtype",      1, I_RT,   0, 0, 0, 0, e_rt,   0);

        // Load-use hazards, flush masking, rt-use and r0 exemptions
        step("lw_a",       1, I_LW3,  0, 0, 0, 0, e_lw3,  0);
        step("add_flush",  1, I_ADD3, 0, 1, 0, 0, b,      0);
        step("lw_b",       1, I_LW3,  0, 0, 0, 0, e_lw3,  0);
        step("add_haz",    1, I_ADD3, 0, 0, 0, 1, b,      0);
        step("add_load",   1, I_ADD3, 0, 0, 0, 0, e_add3, 0);
        step("lw_c",       1, I_LW3,  0, 0, 0, 0, e_lw3,  0);
        step("addi_rt",    1, I_ADDI, 0, 0, 0, 0, e_addi, 0);
        step("lw_d",       1, I_LW3,  0, 0, 0, 0, e_lw3,  0);
        step("sw_haz",     1, I_SW,   0, 0, 0, 1, b,      0);
        step("sw_load",    1, I_SW,   0, 0, 0, 0, e_sw,   0);
        step("lw_r0",      1, I_LW0,  0, 0, 0, 0, e_lw0,  0);
        step("add_r0",     1, I_ADD0, 0, 0, 0, 0, e_add0, 0);

        // ext_stall freezes the register; a pulsed flush is lost, a held one is not
        step("stall1",     1, I_BEQ,  1, 0, 0, 0, e_add0, 0);
        step("stall2_fl",  1, I_BEQ,  1, 1, 0, 0, e_add0, 0);
        step("stall3",     1, I_BEQ,  1, 0, 0, 0, e_add0, 0);
        step("stall_rel",  1, I_BEQ,  0, 0, 0, 0, e_beq,  0);
        step("sf1",        1, I_ORI,  1, 1, 0, 0, e_beq,  0);
        step("sf2",        1, I_ORI,  1, 1, 0, 0, e_beq,  0);
        step("sf3",        1, I_ORI,  1, 1, 0, 0, e_beq,  0);
        step("sf_rel",     1, I_ORI,  0, 1, 0, 0, b,      0);

        // Illegal opcode: ignored when not valid, sticky once seen
        step("ill_nv",     0, I_ILL,  0, 0, 0, 0, b,      0);
        step("ill",        1, I_ILL,  0, 0, 0, 0, b,      1);
        step("after_ill",  1, I_RT,   0, 0, 0, 0, e_rt,   1);
        step("jump",       1, I_J,    0, 0, 0, 0, e_j,    1);

        // Back-to-back ori/beq, then reset mid-stream
        step("ori",        1, I_ORI,  0, 0, 0, 0, e_ori,  1);
        step("beq",        1, I_BEQ,  0, 0, 0, 0, e_beq,  1);
        step("beq_rst",    1, I_BEQ,  0, 0, 1, 0, b,      0);
        step("stall_rst",  1, I_ORI,  1, 1, 1, 0, b,      0);
        step("post_rst",   1, I_ORI,  0, 0, 0, 0, e_ori,  0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
